// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the multi-bank ping-pong buffer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // Bank pointers wrap at nbank, which need not be a power of two.
    function automatic int unsigned next_bank(input int unsigned ptr, input int unsigned nbank);
        return (ptr + 32'd1 >= nbank) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/pp_bankmem.sv
// Simple dual-port RAM: one write port, one registered read port.
module pp_bankmem #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; array contents are left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_buf.sv
// N-bank ping-pong buffer: writer fills banks in ring order, reader drains
// committed banks in the same order.
module pingpong_buf
    import pingpong_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int NBANK    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATASIZE-1:0]        wdata,
    input  logic                       w_req_val,
    input  logic                       w_last,
    output logic                       wfull,
    input  logic                       r_req_val,
    output logic [DATASIZE-1:0]        rdata,
    output logic                       rvalid,
    output logic                       rlast,
    output logic                       rempty,
    output logic [$clog2(NBANK+1)-1:0] bank_cnt
);

    localparam int BLEN = 1 << ADDRSIZE;
    localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CW   = $clog2(NBANK + 1);
    localparam int AW   = BW + ADDRSIZE;

    bank_state_t         state_q [NBANK];
    bank_state_t         state_d [NBANK];
    // Index of the final word of each committed bank (length - 1).
    logic [ADDRSIZE-1:0] last_q  [NBANK];
    logic [ADDRSIZE-1:0] last_d  [NBANK];
    logic [BW-1:0]       wbank_q, wbank_d, rbank_q, rbank_d;
    logic [ADDRSIZE-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic                rvalid_q, rlast_q;
    logic                wr_acc, rd_acc, commit, rd_last;
    logic [CW-1:0]       cnt;

    assign wfull   = (state_q[wbank_q] == BANK_FULL) || (state_q[wbank_q] == BANK_READING);
    assign rempty  = (state_q[rbank_q] == BANK_FREE) || (state_q[rbank_q] == BANK_FILLING);
    assign wr_acc  = w_req_val && !wfull;
    assign rd_acc  = r_req_val && !rempty;
    assign commit  = wr_acc && ((waddr_q == ADDRSIZE'(BLEN - 1)) || w_last);
    assign rd_last = rd_acc && (raddr_q == last_q[rbank_q]);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wbank_d = wbank_q;
        waddr_d = waddr_q;
        rbank_d = rbank_q;
        raddr_d = raddr_q;
        // Writer and reader always own different banks, so both may update.
        if (wr_acc) begin
            if (commit) begin
                state_d[wbank_q] = BANK_FULL;
                last_d[wbank_q]  = waddr_q;
                wbank_d          = BW'(next_bank(32'(wbank_q), NBANK));
                waddr_d          = '0;
            end else begin
                state_d[wbank_q] = BANK_FILLING;
                waddr_d          = waddr_q + ADDRSIZE'(1);
            end
        end
        if (rd_acc) begin
            if (rd_last) begin
                state_d[rbank_q] = BANK_FREE;
                rbank_d          = BW'(next_bank(32'(rbank_q), NBANK));
                raddr_d          = '0;
            end else begin
                state_d[rbank_q] = BANK_READING;
                raddr_d          = raddr_q + ADDRSIZE'(1);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NBANK; i++) begin
            if ((state_q[i] == BANK_FULL) || (state_q[i] == BANK_READING)) begin
                cnt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBANK; i++) begin
                state_q[i] <= BANK_FREE;
            end
            wbank_q  <= '0;
            rbank_q  <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rd_acc;
            rlast_q  <= rd_last;
        end
    end

    always_ff @(posedge clk) begin
        last_q <= last_d;
    end

    pp_bankmem #(
        .DW   (DATASIZE),
        .AW   (AW),
        .DEPTH(NBANK * BLEN)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we_i   (wr_acc),
        .waddr_i({wbank_q, waddr_q}),
        .wdata_i(wdata),
        .re_i   (rd_acc),
        .raddr_i({rbank_q, raddr_q}),
        .rdata_o(rdata)
    );

    assign rvalid   = rvalid_q;
    assign rlast    = rlast_q;
    assign bank_cnt = cnt;

endmodule

// File: tb/tb_pingpong_buf.sv
// Bench for pingpong_buf: a 2-bank and a 3-bank instance share one stimulus
// stream and are each checked against a word/bank queue model.
module tb_pingpong_buf;

    localparam int BLEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       w_req_val, w_last, r_req_val;

    logic       wfull_s  [2];
    logic       rempty_s [2];
    logic       rvalid_s [2];
    logic       rlast_s  [2];
    logic [7:0] rdata_s  [2];
    logic [1:0] bank_cnt_s [2];

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    pingpong_buf #(.DATASIZE(8), .ADDRSIZE(2), .NBANK(2)) dut0 (
        .clk(clk), .rst(rst), .wdata(wdata), .w_req_val(w_req_val), .w_last(w_last),
        .wfull(wfull_s[0]), .r_req_val(r_req_val), .rdata(rdata_s[0]), .rvalid(rvalid_s[0]),
        .rlast(rlast_s[0]), .rempty(rempty_s[0]), .bank_cnt(bank_cnt_s[0])
    );

    pingpong_buf #(.DATASIZE(8), .ADDRSIZE(2), .NBANK(3)) dut1 (
        .clk(clk), .rst(rst), .wdata(wdata), .w_req_val(w_req_val), .w_last(w_last),
        .wfull(wfull_s[1]), .r_req_val(r_req_val), .rdata(rdata_s[1]), .rvalid(rvalid_s[1]),
        .rlast(rlast_s[1]), .rempty(rempty_s[1]), .bank_cnt(bank_cnt_s[1])
    );

    // Model: accepted words in arrival order, committed bank lengths in a ring,
    // and a count of committed-but-unreleased banks.
    logic [7:0] m_dat [2][64];
    int         m_len [2][16];
    int         m_dwr [2], m_drd [2], m_lwr [2], m_lrd [2];
    int         m_fill[2], m_rpos[2], m_ncom[2];
    logic       exp_rvalid [2], exp_rlast [2];
    logic [7:0] exp_rdata [2];

    function automatic int nbanks(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_dwr[d] = 0; m_drd[d] = 0; m_lwr[d] = 0; m_lrd[d] = 0;
                m_fill[d] = 0; m_rpos[d] = 0; m_ncom[d] = 0;
                exp_rvalid[d] = 1'b0; exp_rlast[d] = 1'b0; exp_rdata[d] = 8'h00;
            end else begin
                bit wacc, racc, com, rel;
                wacc = w_req_val && (m_ncom[d] < nbanks(d));
                racc = r_req_val && (m_ncom[d] > 0);
                com = 1'b0;
                rel = 1'b0;
                exp_rvalid[d] = racc;
                exp_rlast[d]  = 1'b0;
                if (racc) begin
                    exp_rdata[d] = m_dat[d][m_drd[d]];
                    m_drd[d]  = (m_drd[d] + 1) % 64;
                    m_rpos[d] = m_rpos[d] + 1;
                    if (m_rpos[d] == m_len[d][m_lrd[d]]) begin
                        exp_rlast[d] = 1'b1;
                        m_lrd[d]  = (m_lrd[d] + 1) % 16;
                        m_rpos[d] = 0;
                        rel = 1'b1;
                    end
                end
                if (wacc) begin
                    m_dat[d][m_dwr[d]] = wdata;
                    m_dwr[d]  = (m_dwr[d] + 1) % 64;
                    m_fill[d] = m_fill[d] + 1;
                    if (m_fill[d] == BLEN || w_last) begin
                        m_len[d][m_lwr[d]] = m_fill[d];
                        m_lwr[d]  = (m_lwr[d] + 1) % 16;
                        m_fill[d] = 0;
                        com = 1'b1;
                    end
                end
                m_ncom[d] = m_ncom[d] + int'(com) - int'(rel);
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("wfull",    d, 32'(wfull_s[d]),    32'(m_ncom[d] == nbanks(d)));
                chk("rempty",   d, 32'(rempty_s[d]),   32'(m_ncom[d] == 0));
                chk("bank_cnt", d, 32'(bank_cnt_s[d]), 32'(m_ncom[d]));
                chk("rvalid",   d, 32'(rvalid_s[d]),   32'(exp_rvalid[d]));
                chk("rlast",    d, 32'(rlast_s[d]),    32'(exp_rlast[d]));
                chk("rdata",    d, 32'(rdata_s[d]),    32'(exp_rdata[d]));
            end
        end
    end

    task automatic cycle(input logic wv, input logic [7:0] wd, input logic wl, input logic rv);
        w_req_val = wv;
        wdata     = wd;
        w_last    = wl;
        r_req_val = rv;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int rcv0, rcv1;
        rst = 1'b1; wdata = 8'h00; w_req_val = 1'b0; w_last = 1'b0; r_req_val = 1'b0;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        chk("rst_wfull",  0, 32'(wfull_s[0]),    32'd0);
        chk("rst_rempty", 0, 32'(rempty_s[0]),   32'd1);
        chk("rst_rvalid", 0, 32'(rvalid_s[0]),   32'd0);
        chk("rst_cnt",    0, 32'(bank_cnt_s[0]), 32'd0);

        // Basic transfer
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("basic_rempty", 0, 32'(rempty_s[0]),   32'd0);
        chk("basic_cnt",    0, 32'(bank_cnt_s[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("basic_rdata", 0, 32'(rdata_s[0]),  32'(8'h10 + i));
            chk("basic_rlast", 0, 32'(rlast_s[0]),  32'(i == 3));
            chk("basic_rvld",  0, 32'(rvalid_s[0]), 32'd1);
        end
        chk("basic_empty_after", 0, 32'(rempty_s[0]),   32'd1);
        chk("basic_cnt_after",   0, 32'(bank_cnt_s[0]), 32'd0);

        // Read while empty: ignored, rdata holds
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("empty_rd_rvalid", 0, 32'(rvalid_s[0]), 32'd0);
        chk("empty_rd_hold",   0, 32'(rdata_s[0]),  32'h13);
        chk("empty_rd_rlast",  0, 32'(rlast_s[0]),  32'd0);

        // Early close
        cycle(1'b1, 8'hA0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("early_d0", 0, 32'(rdata_s[0]), 32'hA0);
        chk("early_l0", 0, 32'(rlast_s[0]), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("early_d1", 0, 32'(rdata_s[0]),  32'hA1);
        chk("early_l1", 0, 32'(rlast_s[0]),  32'd1);
        chk("early_em", 0, 32'(rempty_s[0]), 32'd1);

        // Full condition
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("full_wfull", 0, 32'(wfull_s[0]),    32'd1);
        chk("full_cnt",   0, 32'(bank_cnt_s[0]), 32'd2);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("full_ign_wfull", 0, 32'(wfull_s[0]),    32'd1);
        chk("full_ign_cnt",   0, 32'(bank_cnt_s[0]), 32'd2);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("full_rd0", 0, 32'(rdata_s[0]), 32'(8'h20 + i));
        end
        chk("full_rlast",  0, 32'(rlast_s[0]),    32'd1);
        chk("full_wfree",  0, 32'(wfull_s[0]),    32'd0);
        chk("full_cnt1",   0, 32'(bank_cnt_s[0]), 32'd1);
        cycle(1'b1, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("full_rd1", 0, 32'(rdata_s[0]), 32'(8'h24 + i));
        end
        for (int i = 1; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("full_rd_bank0", 0, 32'(rdata_s[0]), 32'(8'h30 + i));
        end

        // Concurrent streaming; the 3-bank instance wraps 2 -> 0 repeatedly
        do_reset();
        rcv0 = 0;
        rcv1 = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 8'(i * 3 + 1), 1'b0, 1'b1);
            if (rvalid_s[0]) rcv0++;
            if (rvalid_s[1]) rcv1++;
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (rvalid_s[0]) rcv0++;
            if (rvalid_s[1]) rcv1++;
        end
        chk("stream_count", 0, 32'(rcv0), 32'd64);
        chk("stream_count", 1, 32'(rcv1), 32'd64);

        // Irregular traffic with early closes, back-pressure and empty reads
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mid_rd0", 0, 32'(rdata_s[0]), 32'h40);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mid_rd1", 0, 32'(rdata_s[0]), 32'h41);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mid_wfull",  0, 32'(wfull_s[0]),    32'd0);
        chk("mid_rempty", 0, 32'(rempty_s[0]),   32'd1);
        chk("mid_rvalid", 0, 32'(rvalid_s[0]),   32'd0);
        chk("mid_rlast",  0, 32'(rlast_s[0]),    32'd0);
        chk("mid_cnt",    0, 32'(bank_cnt_s[0]), 32'd0);
        chk("mid_rdata",  0, 32'(rdata_s[0]),    32'd0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mid_post_data",  0, 32'(rdata_s[0]),  32'h55);
        chk("mid_post_rlast", 0, 32'(rlast_s[0]),  32'd1);
        chk("mid_post_rvld",  0, 32'(rvalid_s[0]), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pingpong_buf.md
PINGPONG_BUF -- requirements
Module: pingpong_buf

Interface
REQ-001 Parameter DATASIZE, default 8, word width in bits.
REQ-002 Parameter ADDRSIZE, default 4, log2 of words per bank; bank capacity BLEN = 2^ADDRSIZE.
REQ-003 Parameter NBANK, default 2, bank count; legal range 2..8, not required to be a power of two.
REQ-004 Port clk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port wdata  input  DATASIZE  write word.
REQ-007 Port w_req_val  input  1  write request.
REQ-008 Port w_last  input  1  closes the current bank early; qualified by w_req_val.
REQ-009 Port wfull  output  1  no bank available for writing.
REQ-010 Port r_req_val  input  1  read request.
REQ-011 Port rdata  output  DATASIZE  registered read word.
REQ-012 Port rvalid  output  1  rdata is valid this cycle.
REQ-013 Port rlast  output  1  rdata is the final word of its bank.
REQ-014 Port rempty  output  1  no committed bank available for reading.
REQ-015 Port bank_cnt  output  clog2(NBANK+1)  number of committed, unreleased banks.

Function
REQ-016 Each bank SHALL hold a state: FREE, FILLING, FULL or READING.
- FREE -> FILLING on the first accepted write.
- FILLING -> FULL on commit.
- FULL -> READING on the first accepted read.
- READING -> FREE on the read of the last word.
REQ-017 A write is accepted when w_req_val=1 and wfull=0; wdata is stored at (wbank, waddr) and waddr increments.
REQ-018 Commit occurs on an accepted write with waddr=BLEN-1 or w_last=1.
- The committed bank's length is recorded as waddr+1 (range 1..BLEN).
- wbank advances modulo NBANK; waddr resets to 0.
REQ-019 wfull SHALL be 1 exactly when the bank at wbank is FULL or READING; writes issued while wfull=1 SHALL be ignored without side effects.
REQ-020 A read is accepted when r_req_val=1 and rempty=0.
- rdata, rvalid=1 and rlast appear the following cycle (latency 1).
- raddr increments on each accepted read.
REQ-021 rlast SHALL be 1 with the word at raddr = length-1.
- On that read the bank becomes FREE, rbank advances modulo NBANK, and raddr resets to 0.
REQ-022 rempty SHALL be 1 exactly when the bank at rbank is FREE or FILLING; reads while rempty=1 SHALL be ignored, with rvalid=0 the next cycle.
REQ-023 A commit becomes visible to the reader (rempty, bank_cnt) on the cycle after the committing write.
REQ-024 A release becomes visible to the writer (wfull) on the cycle after the rlast read.
REQ-025 A simultaneous accepted write and accepted read SHALL both complete in the same cycle.
REQ-026 bank_cnt SHALL equal the count of banks in FULL or READING, updated with the flag timing of REQ-023/024; it never exceeds NBANK.
REQ-027 When rvalid=0, rdata SHALL hold its previous value, and rlast SHALL be 0.

Reset
REQ-028 While rst=1, at the next clk edge:
- all banks FREE; wbank, rbank, waddr and raddr = 0;
- wfull=0, rempty=1, rvalid=0, rlast=0, bank_cnt=0, rdata=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored and partially written banks; memory contents need not be cleared.

Structure
REQ-030 Shared package pingpong_pkg SHALL hold the bank-state enum and the helper for modulo-NBANK pointer increment.
REQ-031 Storage SHALL be a sub-module pp_bankmem: a simple dual-port RAM of NBANK*BLEN words with registered read and one write port.

Verification
All scenarios use DATASIZE=8, ADDRSIZE=2, NBANK=2 unless stated.
REQ-032 Reset: apply rst=1 for 2 cycles -> wfull=0, rempty=1, rvalid=0, bank_cnt=0.
REQ-033 Basic transfer: write 0x10..0x13, then read 4 words.
- rempty=0 and bank_cnt=1 one cycle after the 4th write.
- rdata returns 0x10, 0x11, 0x12, 0x13, with rlast only on 0x13.
- Afterwards rempty=1 and bank_cnt=0.
REQ-034 Full condition: write 8 words -> wfull=1 and bank_cnt=2.
- A 9th write of 0xFF is ignored.
- Read 4 words; wfull=0 the cycle after rlast.
- The next write lands in bank0.
REQ-035 Early close: write 0xA0, 0xA1 with w_last on 0xA1 -> reading returns 2 words, rlast on 0xA1.
REQ-036 Concurrent traffic: stream writes and reads continuously for 64 words.
- Output order and data match a reference queue.
- No word is lost or duplicated.
- With NBANK=3, wrap across bank 2 -> 0 is verified.
REQ-037 Reset mid-operation: pulse rst after 6 writes and 2 reads -> outputs match REQ-028; a subsequent write of 0x55 then read returns 0x55.
